shift_arb_ctrl: RTL and testbench
=================================

Name: shift_arb_ctrl

Overview:
Round-robin controller that shares one right-shift serializer engine between two requesters. A requester offers a parallel word with a valid/ready handshake. The controller grants one requester, loads the word into the internal right-shift register and shifts it out LSB-first on a single serial line, one bit per clock. It then signals completion and re-arbitrates. It sits between parallel producers and a single serial output lane.

Parameters:
WIDTH, 4, bits per word (>=2)
CNTW, $clog2(WIDTH+1), bit-counter width (derived, do not override)

Ports:
clk  input  1  rising-edge clock
clrb  input  1  asynchronous active-low clear
req0_valid  input  1  requester 0 has a word
req0_data  input  WIDTH  requester 0 word
req0_ready  output  1  requester 0 word accepted this cycle
req1_valid  input  1  requester 1 has a word
req1_data  input  WIDTH  requester 1 word
req1_ready  output  1  requester 1 word accepted this cycle
sout  output  1  serial data, LSB first
sout_valid  output  1  sout carries a payload bit
grant_id  output  1  requester currently owning the engine
busy  output  1  engine not in IDLE
done  output  1  one-cycle pulse after the last bit

Behaviour:
- Reset (clrb=0, async, overrides everything): state=IDLE, shift reg=0, count=0, sout=0, sout_valid=0, done=0, busy=0, grant_id=0, last_grant=1 (so req0 wins first).
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE arbitration (combinational):
  - only one valid: pick it.
  - both valid: pick !last_grant.
  - reqN_ready = (state==IDLE) & reqN_valid & (pick==N); at most one ready high; ready never high outside IDLE.
- Handshake at cycle t (valid & ready): on the edge, shift reg <= that requester's data, grant_id <= N, count <= WIDTH, state <= SHIFT. Data need not be held after t.
- SHIFT (cycles t+1 .. t+WIDTH):
  - sout = shift reg[0], sout_valid=1, busy=1.
  - each edge: reg <= {1'b0, reg[WIDTH-1:1]}, count <= count-1.
  - leave to DONE when count==1.
- DONE (cycle t+WIDTH+1): done=1, sout_valid=0, busy=1; last_grant <= grant_id; state <= IDLE.
- Timing and throughput:
  - earliest next accept is cycle t+WIDTH+2.
  - per-word period is WIDTH+2 cycles.
- Outputs and idle values:
  - sout, sout_valid, done and busy are decoded from registered state and the shift reg (glitch-free, no input-to-output path).
  - sout=0 whenever sout_valid=0.
  - grant_id holds its last value in IDLE.
- Valid deasserted mid-word: no effect; the word is already captured.
- Valid held with no handshake: no side effect.
- Reset mid-SHIFT: the word is abandoned, no done pulse, and re-arbitration restarts with req0 priority.

Test Plan:
1. Reset, then req0_valid=1, req0_data=4'b1011, req1 idle -> req0_ready=1 for one cycle; next 4 cycles sout=1,1,0,1 with sout_valid=1; then done=1 for one cycle; grant_id=0.
2. Both valid continuously from reset, req0=4'hA, req1=4'h5 -> words alternate req0, req1, req0; sout streams 0,1,0,1 / 1,0,1,0; ready pulses spaced exactly 6 cycles apart.
3. req1 alone with 4'h8, then req0 and req1 both valid -> req0 is served next (last_grant=1), then req1.
4. Drop req0_valid and change req0_data to 4'hF during SHIFT of word 4'h3 -> output remains 1,1,0,0; no new ready until IDLE.
5. clrb pulsed low at the second shift bit -> sout, sout_valid, busy and done are all 0 immediately (async); no done pulse; the next grant goes to req0 if both are valid.
6. No valids for 20 cycles -> busy=0, sout_valid=0, done=0, both ready=0 throughout.

Source files
------------

// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter sharing one LSB-first right-shift serializer between two requesters.
// Each word takes WIDTH+2 cycles: accept in IDLE, WIDTH shift cycles, one DONE cycle.
module shift_arb_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clrb,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             grant_id,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              pick;

    // With both requesters valid, the one not served last time wins.
    always_comb begin
        pick       = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = (state_q == StIdle) & req0_valid & ~pick;
        req1_ready = (state_q == StIdle) & req1_valid & pick;
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        count_d      = count_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (req0_ready | req1_ready) begin
                    shreg_d = req1_ready ? req1_data : req0_data;
                    grant_d = req1_ready;
                    count_d = CNTW'(WIDTH);
                    state_d = StShift;
                end
            end
            StShift: begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                count_d = count_q - CNTW'(1);
                if (count_q == CNTW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            count_q      <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            count_q      <= count_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs decode registered state only, so they drop the instant clrb asserts.
    assign sout_valid = (state_q == StShift);
    assign sout       = sout_valid & shreg_q[0];
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Scoreboard bench for shift_arb_ctrl: accepted words push expected bits, serial output pops them.
module tb_shift_arb_ctrl;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             clrb = 1'b1;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_data = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_data = '0;
    logic             req1_ready;
    logic             sout, sout_valid, grant_id, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    shift_arb_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clrb       (clrb),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .grant_id   (grant_id),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model, advanced once per cycle at the falling edge.
    typedef enum {MIdle, MShift, MDone} mstate_e;
    mstate_e          m_state = MIdle;
    int               m_cnt = 0;
    logic             m_last = 1'b1;
    logic             m_grant = 1'b0;
    logic             m_pick;
    logic [WIDTH-1:0] m_word;
    logic             exp_q[$];
    int               acc_cyc[$];
    logic             acc_id[$];
    int               cyc = 0;

    always @(negedge clk) begin
        if (!clrb) begin
            m_state = MIdle;
            m_cnt   = 0;
            m_last  = 1'b1;
            m_grant = 1'b0;
            exp_q.delete();
        end else begin
            case (m_state)
                MIdle: begin
                    m_pick = (req0_valid && req1_valid) ? !m_last : req1_valid;
                    check_eq("rdy0", req0_ready, req0_valid && !m_pick);
                    check_eq("rdy1", req1_ready, req1_valid && m_pick);
                    check_eq("idle_busy", busy, 0);
                    check_eq("idle_svalid", sout_valid, 0);
                    check_eq("idle_sout", sout, 0);
                    check_eq("idle_done", done, 0);
                    check_eq("idle_grant", grant_id, m_grant);
                    if (req0_valid || req1_valid) begin
                        m_word = m_pick ? req1_data : req0_data;
                        for (int i = 0; i < WIDTH; i++) exp_q.push_back(m_word[i]);
                        m_grant = m_pick;
                        m_cnt   = WIDTH;
                        m_state = MShift;
                        acc_cyc.push_back(cyc);
                        acc_id.push_back(m_pick);
                    end
                end
                MShift: begin
                    check_eq("shift_svalid", sout_valid, 1);
                    check_eq("shift_busy", busy, 1);
                    check_eq("shift_done", done, 0);
                    check_eq("shift_grant", grant_id, m_grant);
                    check_eq("shift_rdy", {req0_ready, req1_ready}, 0);
                    if (exp_q.size() == 0) check_eq("sb_empty", 1, 0);
                    else check_eq("sout_bit", sout, exp_q.pop_front());
                    m_cnt--;
                    if (m_cnt == 0) m_state = MDone;
                end
                MDone: begin
                    check_eq("done_pulse", done, 1);
                    check_eq("done_svalid", sout_valid, 0);
                    check_eq("done_sout", sout, 0);
                    check_eq("done_busy", busy, 1);
                    check_eq("done_rdy", {req0_ready, req1_ready}, 0);
                    m_last  = m_grant;
                    m_state = MIdle;
                end
                default: m_state = MIdle;
            endcase
        end
        cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        clrb = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_svalid", sout_valid, 0);
        check_eq("rst_sout", sout, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_grant", grant_id, 0);
        tick(2);
        clrb = 1'b1;
        acc_cyc.delete();
        acc_id.delete();
    endtask

    task automatic wait_acc(input int n, input int limit);
        int k = 0;
        while (acc_id.size() < n && k < limit) begin
            tick();
            k++;
        end
        if (acc_id.size() < n) check_eq("timeout_acc", acc_id.size(), n);
    endtask

    logic [3:0] pat;

    initial begin
        #1;
        // 1: single word from req0
        do_reset();
        req0_data  = 4'b1011;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        pat = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_bit", sout, pat[i]);
            tick();
        end
        check_eq("t1_done", done, 1);
        check_eq("t1_grant", grant_id, 0);
        tick(3);

        // 2: both valid, alternation and 6-cycle spacing
        do_reset();
        req0_data  = 4'hA;
        req1_data  = 4'h5;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_acc(3, 40);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (acc_id.size() >= 3) begin
            check_eq("t2_id0", acc_id[0], 0);
            check_eq("t2_id1", acc_id[1], 1);
            check_eq("t2_id2", acc_id[2], 0);
            check_eq("t2_gap0", acc_cyc[1] - acc_cyc[0], 6);
            check_eq("t2_gap1", acc_cyc[2] - acc_cyc[1], 6);
        end
        tick(8);

        // 3: req1 first, then both -> req0 next, then req1
        do_reset();
        req1_data  = 4'h8;
        req1_valid = 1'b1;
        tick();
        req0_data  = 4'h6;
        req0_valid = 1'b1;
        wait_acc(3, 40);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (acc_id.size() >= 3) begin
            check_eq("t3_id0", acc_id[0], 1);
            check_eq("t3_id1", acc_id[1], 0);
            check_eq("t3_id2", acc_id[2], 1);
        end
        tick(8);

        // 4: valid dropped and data changed mid-word
        do_reset();
        req0_data  = 4'h3;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        req0_data  = 4'hF;
        pat = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            check_eq("t4_bit", sout, pat[i]);
            check_eq("t4_rdy", req0_ready, 0);
            tick();
        end
        check_eq("t4_done", done, 1);
        tick(3);
        check_eq("t4_acc", acc_id.size(), 1);

        // 5: async clear during the second shift bit
        do_reset();
        req0_data  = 4'hA;
        req1_data  = 4'h5;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick(2);
        check_eq("t5_pre_svalid", sout_valid, 1);
        #2;
        clrb = 1'b0;
        #1;
        check_eq("t5_sout", sout, 0);
        check_eq("t5_svalid", sout_valid, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_done", done, 0);
        tick(2);
        acc_cyc.delete();
        acc_id.delete();
        clrb = 1'b1;
        wait_acc(1, 10);
        if (acc_id.size() >= 1) check_eq("t5_first", acc_id[0], 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(8);

        // 6: no traffic for 20 cycles
        do_reset();
        for (int i = 0; i < 20; i++) begin
            check_eq("t6_quiet", {busy, sout_valid, done, req0_ready, req1_ready}, 0);
            tick();
        end
        check_eq("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
